// File: rtl/approx_err_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
// Optional max-error tracking is enabled with ERR_MAX_TRACK_EN.
package approx_err_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    REPORT
  } state_t;

  // idle cycles DRAIN waits once the pipe has emptied
  localparam logic [1:0] DRAIN_IDLE = 2'd2;

  function automatic int ed_w(input int width);
    return width + 1;
  endfunction

  function automatic int sq_w(input int width);
    return 2 * ed_w(width);
  endfunction

  function automatic int acc_w(input int width, input int win_log2);
    return sq_w(width) + win_log2;
  endfunction

  function automatic int sae_w(input int width, input int win_log2);
    return ed_w(width) + win_log2;
  endfunction

endpackage

// File: rtl/approx_add_err_monitor_dist.sv
// Exact sum, absolute distance and square of an approximate-adder sample.
// Three register stages: capture, distance, square; flush kills in-flight valids.
module err_dist_sq
  import approx_err_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     approx,
  output logic               out_valid,
  output logic [WIDTH:0]     out_ed,
  output logic [2*WIDTH+1:0] out_sq,
  output logic               busy
);

  localparam int ED_W = ed_w(WIDTH);
  localparam int SQ_W = sq_w(WIDTH);

  logic            v0, v1, v2;
  logic [WIDTH-1:0] a0, b0;
  logic [ED_W-1:0] x0, ed1, ed2;
  logic [SQ_W-1:0] sq2;
  logic [ED_W-1:0] exact, ed_c;
  logic [SQ_W-1:0] sq_c;

  assign exact = {1'b0, a0} + {1'b0, b0};
  assign ed_c  = (exact >= x0) ? exact - x0 : x0 - exact;
  assign sq_c  = SQ_W'(ed1) * SQ_W'(ed1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0  <= 1'b0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      a0  <= '0;
      b0  <= '0;
      x0  <= '0;
      ed1 <= '0;
      ed2 <= '0;
      sq2 <= '0;
    end else begin
      v0 <= in_valid & ~flush;
      v1 <= v0 & ~flush;
      v2 <= v1 & ~flush;
      if (in_valid) begin
        a0 <= a;
        b0 <= b;
        x0 <= approx;
      end
      if (v0) ed1 <= ed_c;
      if (v1) begin
        ed2 <= ed1;
        sq2 <= sq_c;
      end
    end
  end

  assign out_valid = v2;
  assign out_ed    = ed2;
  assign out_sq    = sq2;
  assign busy      = v0 | v1 | v2;

endmodule

// File: rtl/approx_add_err_monitor.sv
// Windowed SSE/SAE/error-count monitor for an approximate adder.
// Define ERR_MAX_TRACK_EN to also track and report the maximum error.
module approx_add_err_monitor
  import approx_err_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [WIDTH:0]        in_approx,
  input  logic                  clear,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [acc_w(WIDTH, WIN_LOG2)-1:0] res_sse,
  output logic [sae_w(WIDTH, WIN_LOG2)-1:0] res_sae,
  output logic [WIN_LOG2:0]     res_err_cnt
`ifdef ERR_MAX_TRACK_EN
  ,
  output logic [WIDTH:0]        res_max_err
`endif
);

  localparam int ED_W  = ed_w(WIDTH);
  localparam int SQ_W  = sq_w(WIDTH);
  localparam int ACC_W = acc_w(WIDTH, WIN_LOG2);
  localparam int SAE_W = sae_w(WIDTH, WIN_LOG2);
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN = CNT_W'(2 ** WIN_LOG2);

  state_t           state;
  logic             rdy;
  logic             rv;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [1:0]       dcnt;
  logic [ACC_W-1:0] sse;
  logic [SAE_W-1:0] sae;
  logic [CNT_W-1:0] ecnt;
  logic             accept;
  logic             pv;
  logic             busy;
  logic [ED_W-1:0]  ped;
  logic [SQ_W-1:0]  psq;
`ifdef ERR_MAX_TRACK_EN
  logic [ED_W-1:0]  mx;
`endif

  assign in_ready  = rdy;
  assign res_valid = rv;
  assign accept    = in_valid & rdy & ~clear;
  assign cnt_nx    = cnt + CNT_W'(1);

  err_dist_sq #(
    .WIDTH(WIDTH)
  ) u_dist (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .in_valid (accept),
    .a        (in_a),
    .b        (in_b),
    .approx   (in_approx),
    .out_valid(pv),
    .out_ed   (ped),
    .out_sq   (psq),
    .busy     (busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rdy         <= 1'b0;
      rv          <= 1'b0;
      cnt         <= '0;
      dcnt        <= '0;
      sse         <= '0;
      sae         <= '0;
      ecnt        <= '0;
      res_sse     <= '0;
      res_sae     <= '0;
      res_err_cnt <= '0;
`ifdef ERR_MAX_TRACK_EN
      mx          <= '0;
      res_max_err <= '0;
`endif
    end else if (clear) begin
      state <= IDLE;
      rdy   <= 1'b1;
      rv    <= 1'b0;
      cnt   <= '0;
      dcnt  <= '0;
      sse   <= '0;
      sae   <= '0;
      ecnt  <= '0;
`ifdef ERR_MAX_TRACK_EN
      mx    <= '0;
`endif
    end else begin
      if (pv) begin
        sse  <= sse + ACC_W'(psq);
        sae  <= sae + SAE_W'(ped);
        ecnt <= ecnt + CNT_W'(ped != '0);
`ifdef ERR_MAX_TRACK_EN
        if (ped > mx) mx <= ped;
`endif
      end
      unique case (state)
        IDLE, ACCUM: begin
          rdy <= 1'b1;
          if (accept) begin
            cnt   <= cnt_nx;
            state <= ACCUM;
            // saturate exactly at the window size
            if (cnt_nx == WIN) begin
              state <= DRAIN;
              rdy   <= 1'b0;
              dcnt  <= '0;
            end
          end
        end
        DRAIN: begin
          rdy <= 1'b0;
          if (busy) begin
            dcnt <= '0;
          end else if (dcnt == DRAIN_IDLE) begin
            state       <= REPORT;
            rv          <= 1'b1;
            res_sse     <= sse;
            res_sae     <= sae;
            res_err_cnt <= ecnt;
`ifdef ERR_MAX_TRACK_EN
            res_max_err <= mx;
`endif
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        REPORT: begin
          rdy <= 1'b0;
          if (res_ready) begin
            state <= IDLE;
            rv    <= 1'b0;
            rdy   <= 1'b1;
            cnt   <= '0;
            dcnt  <= '0;
            sse   <= '0;
            sae   <= '0;
            ecnt  <= '0;
`ifdef ERR_MAX_TRACK_EN
            mx    <= '0;
`endif
          end
        end
        default: begin
          state <= IDLE;
          rv    <= 1'b0;
        end
      endcase
    end
  end

endmodule
